// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters advanced by a pixel enable, with
// registered sync, blanking, position, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 80,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 400,
  parameter int V_FP     = 16,
  parameter int V_SYNC   = 16,
  parameter int V_BP     = 16,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b1,
  parameter int H_BITS   = 11,
  parameter int V_BITS   = 9,
  parameter int FC_BITS  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic               h_sync,
  output logic               v_sync,
  output logic               disp_ena,
  output logic               n_blank,
  output logic               n_sync,
  output logic [H_BITS-1:0]  col,
  output logic [V_BITS-1:0]  row,
  output logic               line_start,
  output logic               frame_start,
  output logic [FC_BITS-1:0] frame_cnt
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        H_BITS == 0 || V_BITS == 0 || FC_BITS == 0) begin : g_zero_width
      $error("vga_timing_gen: width parameters must be non-zero");
    end
    if (longint'(H_TOT) - 1 > (longint'(1) << H_BITS) - 1) begin : g_h_range
      $error("vga_timing_gen: H_BITS too small for H_TOT");
    end
    if (longint'(V_TOT) - 1 > (longint'(1) << V_BITS) - 1) begin : g_v_range
      $error("vga_timing_gen: V_BITS too small for V_TOT");
    end
  endgenerate

  localparam logic [H_BITS-1:0] H_ACT_END  = H_BITS'(H_ACTIVE);
  localparam logic [H_BITS-1:0] H_SYNC_BEG = H_BITS'(H_ACTIVE + H_FP);
  localparam logic [H_BITS-1:0] H_SYNC_END = H_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_BITS-1:0] H_LAST     = H_BITS'(H_TOT - 1);
  localparam logic [V_BITS-1:0] V_ACT_END  = V_BITS'(V_ACTIVE);
  localparam logic [V_BITS-1:0] V_SYNC_BEG = V_BITS'(V_ACTIVE + V_FP);
  localparam logic [V_BITS-1:0] V_SYNC_END = V_BITS'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_BITS-1:0] V_LAST     = V_BITS'(V_TOT - 1);

  logic [H_BITS-1:0] hc;
  logic [V_BITS-1:0] vc;
  logic h_act, v_act, h_sreg, v_sreg, h_wrap, v_wrap;

  // Region decode of the current (pre-increment) position.
  assign h_act  = (hc < H_ACT_END);
  assign v_act  = (vc < V_ACT_END);
  assign h_sreg = (hc >= H_SYNC_BEG) && (hc < H_SYNC_END);
  assign v_sreg = (vc >= V_SYNC_BEG) && (vc < V_SYNC_END);
  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      disp_ena    <= 1'b0;
      n_blank     <= 1'b0;
      n_sync      <= 1'b1;
      col         <= '0;
      row         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      // Strobes drop on the very next clk, so they stay one clk wide under any pix_en.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        h_sync      <= h_sreg ? H_POL : ~H_POL;
        v_sync      <= v_sreg ? V_POL : ~V_POL;
        disp_ena    <= h_act && v_act;
        n_blank     <= h_act && v_act;
        n_sync      <= ~(h_sreg || v_sreg);
        line_start  <= (hc == '0);
        frame_start <= (hc == '0) && (vc == '0);
        if (h_act) col <= hc;
        if (v_act) row <= vc;
        if (h_wrap) begin
          hc <= '0;
          if (v_wrap) begin
            vc        <= '0;
            frame_cnt <= frame_cnt + FC_BITS'(1);
          end else begin
            vc <= vc + V_BITS'(1);
          end
        end else begin
          hc <= hc + H_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 16x8 raster: hand-written vectors, corner sequences and
// randomised pix_en checked against a pixel-index reference model.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        h_sync, v_sync, disp_ena, n_blank, n_sync, line_start, frame_start;
  logic [10:0] col;
  logic [8:0]  row;
  logic [7:0]  frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b1), .H_BITS(11), .V_BITS(9), .FC_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_sync(h_sync), .v_sync(v_sync), .disp_ena(disp_ena), .n_blank(n_blank),
    .n_sync(n_sync), .col(col), .row(row), .line_start(line_start),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        nb;
    logic        ns;
    logic [10:0] col;
    logic [8:0]  row;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    int   n;
    obs_t exp;
  } vec_t;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   edges    = 0;
  obs_t got;

  always_comb begin
    got     = '0;
    got.hs  = h_sync;
    got.vs  = v_sync;
    got.de  = disp_ena;
    got.nb  = n_blank;
    got.ns  = n_sync;
    got.col = col;
    got.row = row;
    got.ls  = line_start;
    got.fs  = frame_start;
    got.fc  = frame_cnt;
  end

  function automatic obs_t mk(bit hs, bit vs, bit de, bit ns, int c, int r, bit ls, bit fs, int fc);
    obs_t o;
    o.hs = hs; o.vs = vs; o.de = de; o.nb = de; o.ns = ns;
    o.col = 11'(c); o.row = 9'(r); o.ls = ls; o.fs = fs; o.fc = 8'(fc);
    return o;
  endfunction

  // Outputs after e pix_en edges since reset describe pixel e-1 of a 16x8 raster.
  function automatic obs_t model(int e, bit pe);
    int k, x, y;
    bit hs_r, vs_r, de, ls;
    if (e == 0) return mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    k    = e - 1;
    x    = k % 16;
    y    = (k / 16) % 8;
    hs_r = (x >= 10) && (x < 13);
    vs_r = (y >= 5) && (y < 7);
    de   = (x < 8) && (y < 4);
    ls   = pe && (x == 0);
    return mk(!hs_r, vs_r, de, !(hs_r || vs_r), (x < 8) ? x : 7, (y < 4) ? y : 3,
              ls, ls && (y == 0), (e / 128) % 256);
  endfunction

  task automatic check(input string name, input obs_t exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s edges=%0d got=%h expected=%h", name, edges, got, exp);
  endtask

  task automatic check_fc(input string name, input logic [7:0] exp);
    chk_cnt++;
    if (frame_cnt === exp) pass_cnt++;
    else $display("FAIL %s frame_cnt got=%0d expected=%0d", name, frame_cnt, exp);
  endtask

  task automatic step(input bit pe);
    pix_en = pe;
    @(posedge clk);
    #2;
    if (pe && !rst) edges++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    edges = 0;
    rst = 1'b0;
  endtask

  vec_t vecs[10];
  bit   pe;

  initial begin
    vecs[0] = '{0,   mk(1, 0, 0, 1, 0, 0, 0, 0, 0)};
    vecs[1] = '{1,   mk(1, 0, 1, 1, 0, 0, 1, 1, 0)};
    vecs[2] = '{2,   mk(1, 0, 1, 1, 1, 0, 0, 0, 0)};
    vecs[3] = '{10,  mk(1, 0, 0, 1, 7, 0, 0, 0, 0)};
    vecs[4] = '{11,  mk(0, 0, 0, 0, 7, 0, 0, 0, 0)};
    vecs[5] = '{14,  mk(1, 0, 0, 1, 7, 0, 0, 0, 0)};
    vecs[6] = '{17,  mk(1, 0, 1, 1, 0, 1, 1, 0, 0)};
    vecs[7] = '{81,  mk(1, 1, 0, 0, 0, 3, 1, 0, 0)};
    vecs[8] = '{128, mk(1, 0, 0, 1, 7, 3, 0, 0, 1)};
    vecs[9] = '{129, mk(1, 0, 1, 1, 0, 0, 1, 1, 1)};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      repeat (vecs[i].n) step(1'b1);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // pix_en one cycle in three: same sequence, stretched, strobes still one clk.
    do_reset();
    for (int i = 0; i < 3 * 140; i++) begin
      pe = (i % 3) == 0;
      step(pe);
      check("stretch", model(edges, pe));
    end

    // Randomised pix_en against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pe = 1'($urandom_range(0, 1));
      step(pe);
      check("random", model(edges, pe));
    end

    // Asynchronous reset at hc=12, vc=5 of the second frame.
    do_reset();
    repeat (128 + 92) step(1'b1);
    check("pre_reset", model(edges, 1'b1));
    #3 rst = 1'b1;
    #1 check("async_rst", mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #2;
    edges = 0;
    rst = 1'b0;
    step(1'b1);
    check("post_rst", mk(1, 0, 1, 1, 0, 0, 1, 1, 0));
    step(1'b1);
    check("post_rst2", model(edges, 1'b1));

    // Frame counter wrap over 256 frames.
    do_reset();
    for (int i = 0; i < 256 * 128; i++) begin
      step(1'b1);
      if ((edges % 128) == 0 || (edges % 128) == 1) check("wrap_run", model(edges, 1'b1));
      if (edges == 255 * 128) check_fc("fc_255", 8'd255);
    end
    check_fc("fc_wrap", 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
